pb_write_arbiter: RTL

Sequences all writes into the 4-bit pixel buffer (ram2port write side) in the VGA_CLK domain. It shares the single write port between two requesters. The first is NiosII PIO single-pixel writes (address, data and wren). The second is a hardware rectangle-fill engine configured over PIO. It sits between the niosII_processor PIO exports and the pixel_buffer write port.

---
 rtl/pb_pkg.sv | 25 ++
 rtl/sync_edge.sv | 27 ++
 rtl/pb_write_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pb_pkg.sv
// Shared constants and types for the pixel-buffer write arbiter.
package pb_pkg;

    localparam int unsigned H_RES     = 160;
    localparam int unsigned V_RES     = 120;
    localparam int unsigned PIX_COUNT = H_RES * V_RES;
    localparam int unsigned ADDR_W    = 15;
    localparam int unsigned DATA_W    = 4;

    // 9-bit x and 8-bit y intermediates keep X0+W and Y0+H from wrapping
    localparam int unsigned X0_W = 8;
    localparam int unsigned Y0_W = 7;
    localparam int unsigned X_W  = 9;
    localparam int unsigned Y_W  = 8;

    localparam logic [X_W-1:0]    X_LIM    = X_W'(H_RES);
    localparam logic [Y_W-1:0]    Y_LIM    = Y_W'(V_RES);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            meta  <= d;
            sync  <= meta;
            prev  <= sync;
            pulse <= sync & ~prev;
        end
    end

endmodule

// File: rtl/pb_write_arbiter.sv
// Shares the pixel-buffer write port between CPU single-pixel writes
// (priority) and a rectangle-fill engine.
module pb_write_arbiter
    import pb_pkg::*;
(
    input  logic              VGA_CLK,
    input  logic              RESET_N,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [DATA_W-1:0] CPU_DATA,
    input  logic              CPU_WE,
    input  logic [X0_W-1:0]   FILL_X0,
    input  logic [Y0_W-1:0]   FILL_Y0,
    input  logic [X0_W-1:0]   FILL_W,
    input  logic [Y0_W-1:0]   FILL_H,
    input  logic [DATA_W-1:0] FILL_COLOUR,
    input  logic              FILL_START,
    output logic [ADDR_W-1:0] PB_WA,
    output logic [DATA_W-1:0] PB_DATA,
    output logic              PB_WE,
    output logic              FILL_BUSY,
    output logic              FILL_DONE
);

    logic cpu_ev;
    logic fill_ev;

    sync_edge u_cpu_sync (.clk(VGA_CLK), .rst_n(RESET_N), .d(CPU_WE),     .pulse(cpu_ev));
    sync_edge u_fill_sync(.clk(VGA_CLK), .rst_n(RESET_N), .d(FILL_START), .pulse(fill_ev));

    fill_state_e       state, state_d;
    logic [X_W-1:0]    x, x_d, x_start, x_start_d, x_end, x_end_d;
    logic [Y_W-1:0]    y, y_d, y_end, y_end_d;
    logic [ADDR_W-1:0] row_base, row_base_d;
    logic [DATA_W-1:0] colour, colour_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] wa_d;
    logic [DATA_W-1:0] data_d;
    logic              we_d;
    logic              accept, empty_ev;
    logic [X_W-1:0]    x_sum, x_nxt;
    logic [Y_W-1:0]    y_sum, y_nxt;
    logic              rect_empty;

    // Next-state, fill datapath and write-port arbitration
    always_comb begin
        state_d    = state;
        x_d        = x;
        y_d        = y;
        x_start_d  = x_start;
        x_end_d    = x_end;
        y_end_d    = y_end;
        row_base_d = row_base;
        colour_d   = colour;
        last_d     = 1'b0;
        we_d       = 1'b0;
        wa_d       = PB_WA;
        data_d     = PB_DATA;
        accept     = 1'b0;
        empty_ev   = 1'b0;

        x_sum      = X_W'(FILL_X0) + X_W'(FILL_W);
        y_sum      = Y_W'(FILL_Y0) + Y_W'(FILL_H);
        x_nxt      = x + X_W'(1);
        y_nxt      = y + Y_W'(1);
        rect_empty = (FILL_W == '0) || (FILL_H == '0) ||
                     (X_W'(FILL_X0) >= X_LIM) || (Y_W'(FILL_Y0) >= Y_LIM);

        if (cpu_ev) begin
            we_d   = 1'b1;
            wa_d   = CPU_ADDR;
            data_d = CPU_DATA;
        end

        case (state)
            IDLE: begin
                if (fill_ev) begin
                    if (rect_empty) begin
                        empty_ev = 1'b1;
                    end else begin
                        state_d    = FILL;
                        accept     = 1'b1;
                        x_d        = X_W'(FILL_X0);
                        x_start_d  = X_W'(FILL_X0);
                        x_end_d    = (x_sum > X_LIM) ? X_LIM : x_sum;
                        y_d        = Y_W'(FILL_Y0);
                        y_end_d    = (y_sum > Y_LIM) ? Y_LIM : y_sum;
                        row_base_d = ADDR_W'(FILL_Y0) * ROW_STEP;
                        colour_d   = FILL_COLOUR;
                    end
                end
            end
            FILL: begin
                // A CPU event in this cycle stalls the engine in place
                if (!cpu_ev) begin
                    we_d   = 1'b1;
                    wa_d   = row_base + ADDR_W'(x);
                    data_d = colour;
                    if (x_nxt == x_end) begin
                        x_d        = x_start;
                        y_d        = y_nxt;
                        row_base_d = row_base + ROW_STEP;
                        if (y_nxt == y_end) begin
                            state_d = IDLE;
                            last_d  = 1'b1;
                        end
                    end else begin
                        x_d = x_nxt;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge VGA_CLK) begin
        if (!RESET_N) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            x_start   <= '0;
            x_end     <= '0;
            y_end     <= '0;
            row_base  <= '0;
            colour    <= '0;
            last_q    <= 1'b0;
            PB_WA     <= '0;
            PB_DATA   <= '0;
            PB_WE     <= 1'b0;
            FILL_BUSY <= 1'b0;
            FILL_DONE <= 1'b0;
        end else begin
            state     <= state_d;
            x         <= x_d;
            y         <= y_d;
            x_start   <= x_start_d;
            x_end     <= x_end_d;
            y_end     <= y_end_d;
            row_base  <= row_base_d;
            colour    <= colour_d;
            last_q    <= last_d;
            PB_WA     <= wa_d;
            PB_DATA   <= data_d;
            PB_WE     <= we_d;
            // Busy drops and done rises the cycle after the final write is on the port
            if (accept) begin
                FILL_BUSY <= 1'b1;
                FILL_DONE <= 1'b0;
            end else if (last_q) begin
                FILL_BUSY <= 1'b0;
                FILL_DONE <= 1'b1;
            end else if (empty_ev) begin
                FILL_DONE <= 1'b1;
            end
        end
    end

endmodule
